// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between one master and the SRAM slave.
// Signal names follow the AXI channel naming.
interface axi_sram_slave_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int ID_W   = 8,
   parameter int LEN_W  = 4
);
   localparam int STRB_W = DATA_W / 8;

   logic [ID_W-1:0]   AWID;
   logic [ADDR_W-1:0] AWADDR;
   logic [LEN_W-1:0]  AWLEN;
   logic [2:0]        AWSIZE;
   logic [1:0]        AWBURST;
   logic              AWVALID;
   logic              AWREADY;

   logic [DATA_W-1:0] WDATA;
   logic [STRB_W-1:0] WSTRB;
   logic              WLAST;
   logic              WVALID;
   logic              WREADY;

   logic [ID_W-1:0]   BID;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY;

   logic [ID_W-1:0]   ARID;
   logic [ADDR_W-1:0] ARADDR;
   logic [LEN_W-1:0]  ARLEN;
   logic [2:0]        ARSIZE;
   logic [1:0]        ARBURST;
   logic              ARVALID;
   logic              ARREADY;

   logic [ID_W-1:0]   RID;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RLAST;
   logic              RVALID;
   logic              RREADY;

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY
   );

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY,
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY
   );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a word-addressed SRAM, one transaction at a time.
// Optional AXI_SRAM_RANGE_CHECK_EN: out-of-range addresses answer SLVERR.
module axi_sram_slave #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int ID_W   = 8,
   parameter int LEN_W  = 4,
   parameter int DEPTH  = 16384
) (
   input logic               ACLK,
   input logic               ARESET,
   axi_sram_slave_if.slave   bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WR, WRESP, RD} state_t;

   state_t            state, state_nx;
   logic              rr_pref;
   logic [ID_W-1:0]   id_q;
   logic [IDX_W-1:0]  idx_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic              fixed_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              aw_rdy, ar_rdy, w_rdy, b_vld, r_vld;
   logic              aw_win, ar_win;
   logic              aw_hs, ar_hs, w_hs, r_hs;
   logic              last;
   logic              aw_err, ar_err;
   logic [IDX_W-1:0]  aw_idx, ar_idx, idx_step;
   logic              rd_en, rd_err;
   logic [IDX_W-1:0]  rd_idx;
   logic              unused_ok;

   // rr_pref=1 means the read side wins a tie
   assign aw_win = bus.AWVALID & (~bus.ARVALID | ~rr_pref);
   assign ar_win = bus.ARVALID & (~bus.AWVALID | rr_pref);

   assign aw_hs = bus.AWVALID & aw_rdy;
   assign ar_hs = bus.ARVALID & ar_rdy;
   assign w_hs  = bus.WVALID & w_rdy;
   assign r_hs  = bus.RREADY & r_vld;
   assign last  = (cnt_q == len_q);

   assign aw_idx   = bus.AWADDR[LSB +: IDX_W];
   assign ar_idx   = bus.ARADDR[LSB +: IDX_W];
   assign idx_step = fixed_q ? idx_q : idx_q + 1'b1;

`ifdef AXI_SRAM_RANGE_CHECK_EN
   assign aw_err = |bus.AWADDR[ADDR_W-1:LSB+IDX_W];
   assign ar_err = |bus.ARADDR[ADDR_W-1:LSB+IDX_W];
`else
   assign aw_err = 1'b0;
   assign ar_err = 1'b0;
`endif

   // next read: first beat at AR accept, then on every non-final R accept
   assign rd_en  = ar_hs | (r_hs & ~last);
   assign rd_idx = ar_hs ? ar_idx : idx_step;
   assign rd_err = ar_hs ? ar_err : err_q;

   // state register
   always_ff @(posedge ACLK) begin
      if (ARESET) state <= IDLE;
      else        state <= state_nx;
   end

   // next state and handshake outputs
   always_comb begin
      state_nx = state;
      aw_rdy   = 1'b0;
      ar_rdy   = 1'b0;
      w_rdy    = 1'b0;
      b_vld    = 1'b0;
      r_vld    = 1'b0;
      unique case (state)
         IDLE: begin
            aw_rdy = ~ARESET & ~ar_win;
            ar_rdy = ~ARESET & ~aw_win;
            if (bus.AWVALID && aw_rdy)      state_nx = WR;
            else if (bus.ARVALID && ar_rdy) state_nx = RD;
         end
         WR: begin
            w_rdy = 1'b1;
            if (bus.WVALID && last) state_nx = WRESP;
         end
         WRESP: begin
            b_vld = 1'b1;
            if (bus.BREADY) state_nx = IDLE;
         end
         RD: begin
            r_vld = 1'b1;
            if (bus.RREADY && last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // round-robin preference flips only when both sides competed
   always_ff @(posedge ACLK) begin
      if (ARESET)                    rr_pref <= 1'b0;
      else if (aw_hs && bus.ARVALID) rr_pref <= 1'b1;
      else if (ar_hs && bus.AWVALID) rr_pref <= 1'b0;
   end

   // transaction context: captured at address accept, stepped per beat
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         id_q    <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         fixed_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (aw_hs) begin
         id_q    <= bus.AWID;
         idx_q   <= aw_idx;
         len_q   <= bus.AWLEN;
         cnt_q   <= '0;
         fixed_q <= (bus.AWBURST == 2'b00);
         err_q   <= aw_err;
      end else if (ar_hs) begin
         id_q    <= bus.ARID;
         idx_q   <= ar_idx;
         len_q   <= bus.ARLEN;
         cnt_q   <= '0;
         fixed_q <= (bus.ARBURST == 2'b00);
         err_q   <= ar_err;
      end else if (w_hs || (r_hs && !last)) begin
         idx_q <= idx_step;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // byte-strobed memory write, contents survive reset
   always_ff @(posedge ACLK) begin
      if (w_hs && !err_q && !ARESET) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.WSTRB[b]) mem[idx_q][8*b +: 8] <= bus.WDATA[8*b +: 8];
         end
      end
   end

   // synchronous read port, holds while the master stalls
   always_ff @(posedge ACLK) begin
      if (ARESET)     rdata_q <= '0;
      else if (rd_en) rdata_q <= rd_err ? '0 : mem[rd_idx];
   end

   assign bus.AWREADY = aw_rdy;
   assign bus.ARREADY = ar_rdy;
   assign bus.WREADY  = w_rdy;
   assign bus.BVALID  = b_vld;
   assign bus.BID     = id_q;
   assign bus.BRESP   = {err_q, 1'b0};
   assign bus.RVALID  = r_vld;
   assign bus.RID     = id_q;
   assign bus.RDATA   = rdata_q;
   assign bus.RRESP   = {err_q, 1'b0};
   assign bus.RLAST   = r_vld & last;

   assign unused_ok = ^{bus.AWSIZE, bus.ARSIZE, bus.WLAST,
                        bus.AWBURST, bus.ARBURST,
                        bus.AWADDR, bus.ARADDR};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: vector table plus corner sequences.
// Build with +define+AXI_SRAM_RANGE_CHECK_EN to check error responses.
module tb_axi_sram_slave;
   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;

   logic ACLK = 1'b0;
   logic ARESET = 1'b1;
   always #5 ACLK = ~ACLK;

   axi_sram_slave_if bus ();

   axi_sram_slave dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   typedef struct {
      logic             wr;
      logic [31:0]      addr;
      logic [3:0]       len;
      logic [1:0]       burst;
      logic [7:0]       id;
      logic [3:0]       strb;
      logic [3:0][31:0] data;
      logic [1:0]       resp;
      logic             bp;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];
   int total = 0;
   int bad = 0;

   function automatic vec_t mk(
      input logic wr, input logic [31:0] addr, input logic [3:0] len,
      input logic [1:0] burst, input logic [7:0] id, input logic [3:0] strb,
      input logic [31:0] d0, input logic [31:0] d1,
      input logic [31:0] d2, input logic [31:0] d3,
      input logic [1:0] resp, input logic bp);
      vec_t v;
      v.wr = wr; v.addr = addr; v.len = len; v.burst = burst;
      v.id = id; v.strb = strb; v.data = {d3, d2, d1, d0};
      v.resp = resp; v.bp = bp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out, handshake never seen", name);
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic aw_phase(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
      logic ok = 1'b0;
      bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
      bus.AWBURST = burst; bus.AWSIZE = 3'd2; bus.AWVALID = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge ACLK);
         ok = bus.AWREADY;
         step();
      end
      bus.AWVALID = 1'b0;
      if (!ok) tmo("aw_handshake");
   endtask

   task automatic ar_phase(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
      logic ok = 1'b0;
      bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len;
      bus.ARBURST = burst; bus.ARSIZE = 3'd2; bus.ARVALID = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge ACLK);
         ok = bus.ARREADY;
         step();
      end
      bus.ARVALID = 1'b0;
      if (!ok) tmo("ar_handshake");
   endtask

   task automatic w_phase(input logic [3:0] len, input logic [3:0][31:0] data,
                          input logic [3:0] strb);
      logic ok;
      for (int b = 0; b <= int'(len); b++) begin
         bus.WDATA = data[b]; bus.WSTRB = strb;
         bus.WLAST = (b == int'(len)); bus.WVALID = 1'b1;
         ok = 1'b0;
         for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ACLK);
            ok = bus.WREADY;
            step();
         end
         if (!ok) tmo("w_handshake");
      end
      bus.WVALID = 1'b0;
      bus.WLAST = 1'b0;
   endtask

   task automatic b_phase(input logic [7:0] id, input logic [1:0] resp);
      logic ok = 1'b0;
      bus.BREADY = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge ACLK);
         ok = bus.BVALID;
         if (ok) begin
            chk("bid", bus.BID, id);
            chk("bresp", bus.BRESP, resp);
         end
         step();
      end
      bus.BREADY = 1'b0;
      if (!ok) tmo("b_handshake");
      @(negedge ACLK);
      chk("bvalid_clear", bus.BVALID, 1'b0);
      step();
   endtask

   task automatic r_phase(input logic [3:0] len, input logic [3:0][31:0] exp,
                          input logic [7:0] id, input logic [1:0] resp,
                          input logic bp);
      int   b = 0;
      logic rr = 1'b1;
      logic done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         bus.RREADY = rr;
         @(negedge ACLK);
         if (i == 0) chk("rvalid_first", bus.RVALID, 1'b1);
         if (bus.RVALID) begin
            chk("rdata", bus.RDATA, exp[b]);
            chk("rlast", bus.RLAST, b == int'(len));
            chk("rresp", bus.RRESP, resp);
            chk("rid", bus.RID, id);
            if (rr) begin
               if (b == int'(len)) done = 1'b1;
               b++;
            end
         end
         step();
         if (bp) rr = ~rr;
      end
      bus.RREADY = 1'b0;
      if (!done) tmo("r_burst");
      @(negedge ACLK);
      chk("rvalid_clear", bus.RVALID, 1'b0);
      step();
   endtask

   task automatic contend(input logic exp_w, input logic [31:0] val);
      logic [3:0][31:0] d;
      d = {32'h0, 32'h0, 32'h0, val};
      bus.AWID = 8'h3; bus.AWADDR = 32'h300; bus.AWLEN = 4'd0;
      bus.AWBURST = INCR; bus.AWVALID = 1'b1;
      bus.ARID = 8'h7; bus.ARADDR = 32'h300; bus.ARLEN = 4'd0;
      bus.ARBURST = INCR; bus.ARVALID = 1'b1;
      @(negedge ACLK);
      chk("arb_awready", bus.AWREADY, exp_w);
      chk("arb_arready", bus.ARREADY, !exp_w);
      step();
      bus.AWVALID = 1'b0;
      bus.ARVALID = 1'b0;
      if (exp_w) begin
         w_phase(4'd0, d, 4'hF);
         b_phase(8'h3, 2'd0);
      end else begin
         r_phase(4'd0, d, 8'h7, 2'd0, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]      oor_rd, word10;
      logic [1:0]       oor_resp;
      logic [3:0][31:0] e;

`ifdef AXI_SRAM_RANGE_CHECK_EN
      oor_rd = 32'h0;        oor_resp = 2'd2; word10 = 32'hDEADBEEF;
`else
      oor_rd = 32'hDEADBEEF; oor_resp = 2'd0; word10 = 32'h12345678;
`endif

      vecs[0]  = mk(1, 32'h10, 0, INCR, 8'h01, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 32'h10, 0, INCR, 8'h02, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      vecs[2]  = mk(1, 32'h20, 0, INCR, 8'h01, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
      vecs[3]  = mk(1, 32'h20, 0, INCR, 8'h01, 4'h5, 32'h0, 0, 0, 0, 0, 0);
      vecs[4]  = mk(0, 32'h20, 0, INCR, 8'h02, 4'hF, 32'hFF00FF00, 0, 0, 0, 0, 0);
      vecs[5]  = mk(1, 32'h100, 3, INCR, 8'h04, 4'hF, 1, 2, 3, 4, 0, 0);
      vecs[6]  = mk(0, 32'h100, 3, INCR, 8'h05, 4'hF, 1, 2, 3, 4, 0, 1);
      vecs[7]  = mk(1, 32'hFFFC, 1, INCR, 8'h06, 4'hF, 32'hA1, 32'hB2, 0, 0, 0, 0);
      vecs[8]  = mk(0, 32'hFFFC, 0, INCR, 8'h06, 4'hF, 32'hA1, 0, 0, 0, 0, 0);
      vecs[9]  = mk(0, 32'h0, 0, INCR, 8'h06, 4'hF, 32'hB2, 0, 0, 0, 0, 0);
      vecs[10] = mk(0, 32'h100, 3, FIXED, 8'h08, 4'hF, 1, 1, 1, 1, 0, 0);
      vecs[11] = mk(1, 32'h200, 2, FIXED, 8'h09, 4'hF, 5, 6, 7, 0, 0, 0);
      vecs[12] = mk(0, 32'h200, 0, INCR, 8'h09, 4'hF, 7, 0, 0, 0, 0, 0);
      vecs[13] = mk(0, 32'h10010, 0, INCR, 8'h0A, 4'hF, oor_rd, 0, 0, 0, oor_resp, 0);
      vecs[14] = mk(1, 32'h10010, 0, INCR, 8'h0B, 4'hF, 32'h12345678, 0, 0, 0, oor_resp, 0);
      vecs[15] = mk(0, 32'h10, 0, INCR, 8'h0C, 4'hF, word10, 0, 0, 0, 0, 0);
      vecs[16] = mk(0, 32'hFFFC, 1, INCR, 8'h0D, 4'hF, 32'hA1, 32'hB2, 0, 0, 0, 0);

      bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0;
      bus.AWBURST = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
      bus.BREADY = 1'b0;
      bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0;
      bus.ARBURST = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b0;

      repeat (3) step();
      @(negedge ACLK);
      chk("rst_awready", bus.AWREADY, 1'b0);
      chk("rst_arready", bus.ARREADY, 1'b0);
      chk("rst_wready", bus.WREADY, 1'b0);
      chk("rst_bvalid", bus.BVALID, 1'b0);
      chk("rst_rvalid", bus.RVALID, 1'b0);
      chk("rst_rlast", bus.RLAST, 1'b0);
      chk("rst_rdata", bus.RDATA, 32'h0);
      chk("rst_bid", bus.BID, 8'h0);
      step();
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("idle_awready", bus.AWREADY, 1'b1);
      chk("idle_arready", bus.ARREADY, 1'b1);
      step();

      for (int n = 0; n < NV; n++) begin
         if (vecs[n].wr) begin
            aw_phase(vecs[n].id, vecs[n].addr, vecs[n].len, vecs[n].burst);
            w_phase(vecs[n].len, vecs[n].data, vecs[n].strb);
            b_phase(vecs[n].id, vecs[n].resp);
         end else begin
            ar_phase(vecs[n].id, vecs[n].addr, vecs[n].len, vecs[n].burst);
            r_phase(vecs[n].len, vecs[n].data, vecs[n].id,
                    vecs[n].resp, vecs[n].bp);
         end
      end

      contend(1'b1, 32'h33);
      contend(1'b0, 32'h33);
      contend(1'b1, 32'h44);

      ar_phase(8'h09, 32'h100, 4'd3, INCR);
      bus.RREADY = 1'b1;
      @(negedge ACLK);
      chk("rst_mid_beat1", bus.RDATA, 32'd1);
      step();
      @(negedge ACLK);
      chk("rst_mid_beat2", bus.RDATA, 32'd2);
      ARESET = 1'b1;
      bus.RREADY = 1'b0;
      step();
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("rst_mid_rvalid", bus.RVALID, 1'b0);
      chk("rst_mid_rlast", bus.RLAST, 1'b0);
      chk("rst_mid_arready", bus.ARREADY, 1'b1);
      chk("rst_mid_awready", bus.AWREADY, 1'b1);
      step();

      e = {32'h0, 32'h0, 32'h0, word10};
      ar_phase(8'h0E, 32'h10, 4'd0, INCR);
      r_phase(4'd0, e, 8'h0E, 2'd0, 1'b0);
      e = {32'h0, 32'h0, 32'h0, 32'h44};
      ar_phase(8'h0F, 32'h300, 4'd0, INCR);
      r_phase(4'd0, e, 8'h0F, 2'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
